fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the five-stage pipeline: owns the PC, issues requests to instruction memory over a single-outstanding req/rvalid handshake, and fills the IF/ID pipeline register. It is the consumer of the controller's `PCSrc`, `Stall` and `Flush` outputs. It applies redirects, holds the stage under stall, and squashes wrong-path fetches, including a fetch already in flight.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC after reset.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous active-high reset
- `PCSrc`  in  2  00 PC+4, 01 branch target, 10 JALR target, 11 JAL target
- `Stall`  in  1  hold IF/ID and PC
- `Flush`  in  1  invalidate IF/ID
- `branch_target`  in  32  EX-computed branch target
- `jalr_target`  in  32  EX-computed rs1+imm
- `jal_target`  in  32  JAL target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, stable while `imem_req`=1
- `imem_rvalid`  in  1  response valid (completes the request)
- `imem_rdata`  in  32  instruction word
- `IF_ID_valid`  out  1  IF/ID holds a real instruction
- `IF_ID_instr`  out  32  instruction, NOP 32'h0000_0013 when invalid
- `IF_ID_pc`  out  32  PC of `IF_ID_instr`
- `IF_ID_pc4`  out  32  `IF_ID_pc`+4

## Operation
- Redirect = `PCSrc`≠00. Target: 01 `branch_target`, 10 `jalr_target` with bit0 cleared, 11 `jal_target`.
- Priority each cycle: redirect > `Flush` > `Stall` > normal advance.
- FSM states:
  - S_REQ: `imem_req`=1, `imem_addr`=pc.
    - On `imem_rvalid` with no redirect and no Flush:
      - With `Stall`=0: load IF/ID (valid=1), pc+=4, stay in S_REQ.
      - With `Stall`=1: capture into the hold buffer, go to S_HOLD.
    - On `imem_rvalid` with a redirect or Flush: drop the data. On a redirect, pc=target.
    - On a redirect without `imem_rvalid`: pc=target and go to S_DRAIN. The address register keeps the old address.
  - S_DRAIN: `imem_req`=1 with the old address. On `imem_rvalid`, discard the data and go to S_REQ. A further redirect updates pc; the latest redirect wins.
  - S_HOLD: `imem_req`=0.
    - When `Stall` falls: move the buffer into IF/ID, pc+=4, go to S_REQ.
    - On a redirect: drop the buffer, pc=target, go to S_REQ.
    - On `Flush`: drop the buffer, go to S_REQ, pc unchanged. The refetch then occurs.
- IF/ID register:
  - Redirect or `Flush`: valid=0 and instr=NOP.
  - `Stall` (without redirect or Flush): hold all fields.
  - Otherwise: valid=0 (bubble) when no instruction is delivered this cycle.
- pc arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - state S_REQ, pc=`RESET_PC`
  - `imem_req`=0 while `rst`=1, and 1 on the first cycle after release with `imem_addr`=`RESET_PC`
  - `IF_ID_valid`=0, `IF_ID_instr`=NOP, `IF_ID_pc`=`RESET_PC`, `IF_ID_pc4`=`RESET_PC`+4
- Latency: `imem_rvalid` in cycle N puts the instruction in IF/ID at the edge ending cycle N. The next request is issued in cycle N+1.
- With zero-wait memory (rvalid in the same cycle as req), throughput is one instruction per cycle.
- The redirect target is requested in the cycle after the redirect in S_REQ/S_HOLD. From S_DRAIN, it is requested in the cycle after the draining `imem_rvalid`.
- Reset asserted mid-fetch: all state returns to reset values immediately. Memory must abandon any outstanding request on reset.
- `imem_rvalid` outside S_REQ/S_DRAIN is ignored.

## Configuration
- `FETCH_STATS_EN` defined adds three outputs, each 32 bits, wrapping, and reset to 0:
  - `stat_fetched`: instructions loaded into IF/ID
  - `stat_squashed`: responses discarded, plus hold buffers dropped
  - `stat_stall_cycles`: cycles with `Stall`=1
- `FETCH_STATS_EN` undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg` contains:
  - FSM state enum (S_REQ, S_DRAIN, S_HOLD)
  - `PCSrc` encoding constants
  - `NOP_INSTR` = 32'h0000_0013
- One sub-module, `fetch_hold_buffer`: a one-entry instruction+PC buffer with load/drop/valid.
- Target mux, FSM and IF/ID register live in `fetch_unit`.

## Test plan
- Reset release, zero-wait memory, no stall → `imem_addr` 0,4,8,C on consecutive cycles; `IF_ID_pc` follows one cycle later with valid=1.
- `Stall`=1 for 3 cycles when rvalid arrives for addr 0x8 → FSM in S_HOLD, `imem_req`=0, IF/ID frozen. After `Stall` falls, `IF_ID_pc`=0x8 and the next request is 0xC.
- 3-cycle-latency memory; `PCSrc`=01 with `branch_target`=0x100 during the wait for 0x10 → the 0x10 response is discarded and IF_ID_valid stays 0. The next `imem_addr` is 0x100.
- `PCSrc`=10, `jalr_target`=0x203 → fetch at 0x202; IF/ID invalid in the redirect cycle.
- `Flush` in S_HOLD holding 0x20 → buffer dropped, refetch of 0x20, `IF_ID_instr`=NOP until delivered.
- With `FETCH_STATS_EN`, the second and third scenarios combined → `stat_squashed`=1 and `stat_stall_cycles`=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding, PCSrc encodings and the canonical NOP word.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;
    localparam logic [1:0] PCSRC_JAL    = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry instruction+PC buffer parking a fetched word while the stage is stalled.
// Latency: load visible the cycle after the load edge. Backpressure: none, owner sequences load/drop.
// Load takes precedence over drop; drop also serves as "consumed".
module fetch_hold_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drop,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        buf_valid,
    output logic [31:0] buf_instr,
    output logic [31:0] buf_pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0000_0000;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_instr <= load_instr;
            buf_pc    <= load_pc;
        end else if (drop) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem req/rvalid, fills IF/ID; FETCH_STATS_EN adds counters.
// Latency: rvalid in cycle N lands in IF/ID at the edge ending N; next request in N+1.
// Backpressure: Stall parks a returning word in the hold buffer and drops imem_req until released.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] jal_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        IF_ID_valid,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc4
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_squashed,
    output logic [31:0] stat_stall_cycles
`endif
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  drain_addr, drain_addr_nxt;
    logic [31:0]  redirect_pc;
    logic         redirect;
    logic         deliver_mem;
    logic         deliver_buf;
    logic         buf_load;
    logic         buf_squash;
    logic         hold_vld;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc;

    assign redirect = (PCSrc != PCSRC_PC4);

    always_comb begin
        redirect_pc = pc;
        case (PCSrc)
            PCSRC_BRANCH: redirect_pc = branch_target;
            PCSRC_JALR:   redirect_pc = {jalr_target[31:1], 1'b0};
            PCSRC_JAL:    redirect_pc = jal_target;
            default:      redirect_pc = pc;
        endcase
    end

    // While draining, the bus must keep showing the abandoned address until it completes.
    assign imem_req  = !rst && (state != S_HOLD);
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        deliver_mem    = 1'b0;
        deliver_buf    = 1'b0;
        buf_load       = 1'b0;
        buf_squash     = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_nxt = redirect_pc;
                    end else if (Flush) begin
                        pc_nxt = pc;
                    end else if (Stall) begin
                        buf_load  = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        deliver_mem = 1'b1;
                        pc_nxt      = pc + 32'd4;
                    end
                end else if (redirect) begin
                    pc_nxt         = redirect_pc;
                    drain_addr_nxt = pc;
                    state_nxt      = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    buf_squash = 1'b1;
                    pc_nxt     = redirect_pc;
                    state_nxt  = S_REQ;
                end else if (Flush) begin
                    buf_squash = 1'b1;
                    state_nxt  = S_REQ;
                end else if (!Stall && hold_vld) begin
                    deliver_buf = 1'b1;
                    pc_nxt      = pc + 32'd4;
                    state_nxt   = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
        end
    end

    fetch_hold_buffer u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drop       (buf_squash || deliver_buf),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .buf_valid  (hold_vld),
        .buf_instr  (hold_instr),
        .buf_pc     (hold_pc)
    );

    // IF/ID: squash beats stall; an unstalled cycle without a delivery is a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_valid <= 1'b0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_pc    <= RESET_PC;
        end else if (redirect || Flush) begin
            IF_ID_valid <= 1'b0;
            IF_ID_instr <= NOP_INSTR;
        end else if (!Stall) begin
            if (deliver_mem) begin
                IF_ID_valid <= 1'b1;
                IF_ID_instr <= imem_rdata;
                IF_ID_pc    <= pc;
            end else if (deliver_buf) begin
                IF_ID_valid <= 1'b1;
                IF_ID_instr <= hold_instr;
                IF_ID_pc    <= hold_pc;
            end else begin
                IF_ID_valid <= 1'b0;
                IF_ID_instr <= NOP_INSTR;
            end
        end
    end

    assign IF_ID_pc4 = IF_ID_pc + 32'd4;

`ifdef FETCH_STATS_EN
    logic rsp_discard;

    assign rsp_discard = imem_rvalid &&
                         ((state == S_DRAIN) || ((state == S_REQ) && (redirect || Flush)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetched      <= 32'd0;
            stat_squashed     <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (deliver_mem || deliver_buf) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (rsp_discard || buf_squash) begin
                stat_squashed <= stat_squashed + 32'd1;
            end
            if (Stall) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
